// File: rtl/report_pkg.sv
// Shared constants, FSM encodings and BCD helper for the inspection report transmitter.
package report_pkg;

  localparam int unsigned FRAME_LEN = 14;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned BCD_W     = 16;

  localparam logic [7:0] TERM_BYTE = 8'hFF;
  localparam logic [7:0] ASC_N     = 8'h6E;
  localparam logic [7:0] ASC_DOT   = 8'h2E;
  localparam logic [7:0] ASC_V     = 8'h76;
  localparam logic [7:0] ASC_A     = 8'h61;
  localparam logic [7:0] ASC_L     = 8'h6C;
  localparam logic [7:0] ASC_EQ    = 8'h3D;
  localparam logic [7:0] ASC_ZERO  = 8'h30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_NEXT = 2'd3
  } state_e;

  // Frame kind doubles as the ASCII offset of the object id ('0','1','2')
  typedef enum logic [1:0] {
    KIND_GOOD  = 2'd0,
    KIND_BAD   = 2'd1,
    KIND_TOTAL = 2'd2
  } kind_e;

  // Four-digit BCD increment by ripple of per-digit carries; 9999 wraps to 0000
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic             carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser; done_o pulses during the final cycle of the stop bit.
module uart_byte_tx #(
  parameter int unsigned CLK_FREQ = 27_000_000,
  parameter int unsigned UART_BPS = 9600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       done_o
);

  localparam int unsigned BIT_CYC = CLK_FREQ / UART_BPS;
  localparam int unsigned CNT_W   = $clog2(BIT_CYC);

  logic             active;
  logic [3:0]       bit_idx;
  logic [CNT_W-1:0] cnt;
  logic [8:0]       shreg;

  // bit_idx 0 is the start bit, 1..8 data LSB first, 9 the stop bit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active  <= 1'b0;
      bit_idx <= 4'd0;
      cnt     <= '0;
      shreg   <= '1;
      tx_o    <= 1'b1;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (!active) begin
        if (start_i) begin
          active  <= 1'b1;
          tx_o    <= 1'b0;
          shreg   <= {1'b1, data_i};
          bit_idx <= 4'd0;
          cnt     <= '0;
        end
      end else begin
        // Flag completion one cycle early so the caller can restart with minimal gap
        if (bit_idx == 4'd9 && cnt == CNT_W'(BIT_CYC - 2)) begin
          done_o <= 1'b1;
        end
        if (cnt == CNT_W'(BIT_CYC - 1)) begin
          cnt <= '0;
          if (bit_idx == 4'd9) begin
            active <= 1'b0;
            tx_o   <= 1'b1;
          end else begin
            tx_o    <= shreg[0];
            shreg   <= {1'b1, shreg[8:1]};
            bit_idx <= bit_idx + 4'd1;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/inspect_report_tx.sv
// Counts good/bad tile pulses in BCD and reports them as "nX.val=DDDD" frames over UART.
// Define REPORT_RATE_EN to also keep a total counter and send an n2 frame after each report.
module inspect_report_tx
  import report_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 27_000_000,
  parameter int unsigned UART_BPS = 9600
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic good_i,
  input  logic bad_i,
  output logic uart_tx_o,
  output logic busy_o
);

  state_e           state, state_n;
  kind_e            kind, kind_sel_c;
  logic [BCD_W-1:0] good_cnt, bad_cnt, snap, snap_sel_c;
  logic [IDX_W-1:0] idx;
  logic             started, rst_d, pend_g, pend_b;
  logic             good_v_c, bad_v_c, start_c, load_c, last_c, done;
  logic             pend_g_n_c, pend_b_n_c, pend_any_c, pend_any_n_c, busy_n_c;
  logic [7:0]       tx_byte_c;
`ifdef REPORT_RATE_EN
  logic [BCD_W-1:0] total_cnt;
  logic             pend_t, pend_t_n_c;
`endif

  // Masks pulses in the first clock edge after reset release
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rst_d <= 1'b1;
    else       rst_d <= 1'b0;
  end

  assign good_v_c = good_i & ~rst_d;
  assign bad_v_c  = bad_i  & ~rst_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      if (good_v_c) good_cnt <= bcd_inc(good_cnt);
      if (bad_v_c)  bad_cnt  <= bcd_inc(bad_cnt);
    end
  end

`ifdef REPORT_RATE_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      total_cnt <= '0;
    end else begin
      case ({good_v_c, bad_v_c})
        2'b11:        total_cnt <= bcd_inc(bcd_inc(total_cnt));
        2'b10, 2'b01: total_cnt <= bcd_inc(total_cnt);
        default:      ;
      endcase
    end
  end
`endif

  // Frame selection: total report first, then good before bad
  always_comb begin
    kind_sel_c = KIND_BAD;
    snap_sel_c = bad_cnt;
    if (pend_g) begin
      kind_sel_c = KIND_GOOD;
      snap_sel_c = good_cnt;
    end
`ifdef REPORT_RATE_EN
    if (pend_t) begin
      kind_sel_c = KIND_TOTAL;
      snap_sel_c = total_cnt;
    end
`endif
  end

  // Pending flags: a new pulse wins over a same-cycle load so its count is not lost
  always_comb begin
    pend_g_n_c = (pend_g & ~(load_c & (kind_sel_c == KIND_GOOD))) | good_v_c;
    pend_b_n_c = (pend_b & ~(load_c & (kind_sel_c == KIND_BAD)))  | bad_v_c;
`ifdef REPORT_RATE_EN
    pend_t_n_c   = (pend_t & ~(load_c & (kind_sel_c == KIND_TOTAL))) | (last_c & (kind != KIND_TOTAL));
    pend_any_c   = pend_g | pend_b | pend_t;
    pend_any_n_c = pend_g_n_c | pend_b_n_c | pend_t_n_c;
`else
    pend_any_c   = pend_g | pend_b;
    pend_any_n_c = pend_g_n_c | pend_b_n_c;
`endif
    busy_n_c = (state_n != ST_IDLE) | pend_any_n_c;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_g <= 1'b0;
      pend_b <= 1'b0;
      busy_o <= 1'b0;
`ifdef REPORT_RATE_EN
      pend_t <= 1'b0;
`endif
    end else begin
      pend_g <= pend_g_n_c;
      pend_b <= pend_b_n_c;
      busy_o <= busy_n_c;
`ifdef REPORT_RATE_EN
      pend_t <= pend_t_n_c;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_n;
  end

  // A raw pulse in IDLE moves straight to LOAD to meet the three-cycle start latency
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (pend_any_c | good_v_c | bad_v_c) state_n = ST_LOAD;
      ST_LOAD: state_n = ST_SEND;
      ST_SEND: if (started & done) state_n = ST_NEXT;
      ST_NEXT: state_n = last_c ? ST_IDLE : ST_SEND;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    load_c  = (state == ST_LOAD);
    start_c = (state == ST_SEND) & ~started;
    last_c  = (state == ST_NEXT) & (idx == IDX_W'(FRAME_LEN - 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      kind    <= KIND_GOOD;
      snap    <= '0;
      idx     <= '0;
      started <= 1'b0;
    end else begin
      if (load_c) begin
        kind    <= kind_sel_c;
        snap    <= snap_sel_c;
        idx     <= '0;
        started <= 1'b0;
      end
      if (start_c) started <= 1'b1;
      if (state == ST_NEXT) begin
        started <= 1'b0;
        if (!last_c) idx <= idx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    tx_byte_c = TERM_BYTE;
    case (idx)
      4'd0:    tx_byte_c = ASC_N;
      4'd1:    tx_byte_c = ASC_ZERO + {6'b0, kind};
      4'd2:    tx_byte_c = ASC_DOT;
      4'd3:    tx_byte_c = ASC_V;
      4'd4:    tx_byte_c = ASC_A;
      4'd5:    tx_byte_c = ASC_L;
      4'd6:    tx_byte_c = ASC_EQ;
      4'd7:    tx_byte_c = ASC_ZERO | {4'h0, snap[15:12]};
      4'd8:    tx_byte_c = ASC_ZERO | {4'h0, snap[11:8]};
      4'd9:    tx_byte_c = ASC_ZERO | {4'h0, snap[7:4]};
      4'd10:   tx_byte_c = ASC_ZERO | {4'h0, snap[3:0]};
      default: tx_byte_c = TERM_BYTE;
    endcase
  end

  uart_byte_tx #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) u_uart (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_c),
    .data_i  (tx_byte_c),
    .tx_o    (uart_tx_o),
    .done_o  (done)
  );

endmodule

// File: tb/tb_inspect_report_tx.sv
// Directed bench for inspect_report_tx at 10 clocks per UART bit with a line decoder.
module tb_inspect_report_tx;

  localparam int BIT = 10;

  logic clk = 1'b0;
  logic rst_i, good_i, bad_i, uart_tx_o, busy_o;

  int unsigned cyc = 0;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          rd_ptr   = 0;
  logic [7:0]  byte_q[$];
  int unsigned start_q[$];

  inspect_report_tx #(.CLK_FREQ(1000), .UART_BPS(100)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .good_i    (good_i),
    .bad_i     (bad_i),
    .uart_tx_o (uart_tx_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: samples mid-bit, drops any byte interrupted by reset
  initial begin : uart_mon
    logic [7:0]  b;
    bit          abort;
    int unsigned st;
    forever begin
      @(negedge clk);
      if (uart_tx_o === 1'b0 && rst_i === 1'b0) begin
        st    = cyc;
        abort = 1'b0;
        b     = '0;
        repeat (BIT / 2) begin @(negedge clk); if (rst_i) abort = 1'b1; end
        for (int k = 0; k < 8; k++) begin
          repeat (BIT) begin @(negedge clk); if (rst_i) abort = 1'b1; end
          b[k] = uart_tx_o;
        end
        repeat (BIT) begin @(negedge clk); if (rst_i) abort = 1'b1; end
        if (!abort && uart_tx_o === 1'b1) begin
          byte_q.push_back(b);
          start_q.push_back(st);
        end
      end
    end
  end

  function automatic logic [111:0] exp_frame(input logic [7:0] kc, input logic [15:0] bcd);
    return {8'h6E, kc, 8'h2E, 8'h76, 8'h61, 8'h6C, 8'h3D,
            8'h30 | {4'h0, bcd[15:12]}, 8'h30 | {4'h0, bcd[11:8]},
            8'h30 | {4'h0, bcd[7:4]},   8'h30 | {4'h0, bcd[3:0]},
            24'hFFFFFF};
  endfunction

  task automatic check(input string tag, input logic [111:0] obs, input logic [111:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] kc, input logic [15:0] bcd);
    int             waited = 0;
    logic [111:0]   obs = '0;
    while (byte_q.size() < rd_ptr + 14 && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    if (byte_q.size() >= rd_ptr + 14) begin
      for (int i = 0; i < 14; i++) obs = {obs[103:0], byte_q[rd_ptr + i]};
      rd_ptr += 14;
    end
    check(tag, obs, exp_frame(kc, bcd));
  endtask

  task automatic wait_not_busy(input int budget);
    int n = 0;
    while (busy_o !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse(input logic g, input logic b);
    @(negedge clk);
    good_i = g;
    bad_i  = b;
    @(negedge clk);
    good_i = 1'b0;
    bad_i  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    rd_ptr = byte_q.size();
  endtask

  initial begin : stim
    int f0, mn, mx, d, pend, n;
    rst_i  = 1'b1;
    good_i = 1'b0;
    bad_i  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_tx",   112'(uart_tx_o), 112'(1'b1));
    check("reset_busy", 112'(busy_o),    112'(1'b0));
    rst_i = 1'b0;
    repeat (3) @(negedge clk);

    // Single good pulse: latency, frame content, byte spacing, busy release
    f0 = byte_q.size();
    rd_ptr = f0;
    good_i = 1'b1;
    @(negedge clk);
    good_i = 1'b0;
    check("busy_after_pulse", 112'(busy_o), 112'(1'b1));
    @(negedge clk);
    check("tx_idle_cycle2", 112'(uart_tx_o), 112'(1'b1));
    @(negedge clk);
    check("start_bit_cycle3", 112'(uart_tx_o), 112'(1'b0));
    check_frame("good_frame", 8'h30, 16'h0001);
    mn = 0; mx = 1000;
    if (byte_q.size() >= f0 + 14) begin
      mn = 1000; mx = 0;
      for (int i = 0; i < 13; i++) begin
        d = int'(start_q[f0 + i + 1] - start_q[f0 + i]);
        if (d < mn) mn = d;
        if (d > mx) mx = d;
      end
    end
    check("byte_spacing_ok", 112'(mn >= 100 && mx <= 102), 112'(1'b1));
    wait_not_busy(50);
    check("busy_drop", 112'(busy_o), 112'(1'b0));

    // Simultaneous good and bad: good first
    do_reset();
    pulse(1'b1, 1'b1);
    check_frame("both_good", 8'h30, 16'h0001);
    check_frame("both_bad",  8'h31, 16'h0001);
    wait_not_busy(200);

    // Three bad pulses during one good frame coalesce into one bad frame
    do_reset();
    pulse(1'b1, 1'b0);
    repeat (3) begin
      repeat (150) @(negedge clk);
      pulse(1'b0, 1'b1);
    end
    check_frame("coal_good", 8'h30, 16'h0001);
    check_frame("coal_bad",  8'h31, 16'h0003);
    wait_not_busy(200);
    repeat (50) @(negedge clk);
    pend = byte_q.size() - rd_ptr;
    check("coal_no_extra", 112'(pend), 112'(0));

    // 10000 good pulses wrap the counter to 0000
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      good_i = 1'b1;
    end
    @(negedge clk);
    good_i = 1'b0;
    wait_not_busy(20000);
    n = byte_q.size() - rd_ptr;
    if (n >= 14) rd_ptr = byte_q.size() - 14;
    check_frame("wrap_0000", 8'h30, 16'h0000);
    wait_not_busy(200);
    pulse(1'b1, 1'b0);
    check_frame("wrap_0001", 8'h30, 16'h0001);
    wait_not_busy(200);

    // Reset in the middle of byte 5
    do_reset();
    pulse(1'b1, 1'b0);
    n = 0;
    while (byte_q.size() < rd_ptr + 5 && n < 2000) begin @(negedge clk); n++; end
    n = 0;
    while (uart_tx_o !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    #1;
    check("abort_tx_high", 112'(uart_tx_o), 112'(1'b1));
    check("abort_busy_low", 112'(busy_o), 112'(1'b0));
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    rd_ptr = byte_q.size();
    repeat (300) @(negedge clk);
    pend = byte_q.size() - rd_ptr;
    check("abort_quiet", 112'(pend), 112'(0));
    pulse(1'b1, 1'b0);
    check_frame("abort_restart", 8'h30, 16'h0001);
    wait_not_busy(200);

`ifdef REPORT_RATE_EN
    do_reset();
    pulse(1'b1, 1'b0);
    check_frame("rate_n0", 8'h30, 16'h0001);
    check_frame("rate_n2a", 8'h32, 16'h0001);
    wait_not_busy(200);
    pulse(1'b0, 1'b1);
    check_frame("rate_n1", 8'h31, 16'h0001);
    check_frame("rate_n2b", 8'h32, 16'h0002);
    wait_not_busy(200);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/inspect_report_tx.md
INSPECT_REPORT_TX -- requirements
Module: inspect_report_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 27_000_000: input clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 9600: serial-screen baud rate.
REQ-003 SHALL have port clk_i  input  1  system clock; the block uses one clock only.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port good_i  input  1  single-cycle pulse: tile judged good.
REQ-006 SHALL have port bad_i  input  1  single-cycle pulse: tile judged defective.
REQ-007 SHALL have port uart_tx_o  output  1  8N1 UART line to the serial screen; idles high.
REQ-008 SHALL have port busy_o  output  1  high while a frame is being sent or a frame is pending.

Function
REQ-009 SHALL hold two 4-digit BCD counters, good_cnt and bad_cnt.
- Each counter increments by 1 on its pulse.
- Each counter wraps from 9999 to 0000.
REQ-010 SHALL count a pulse on every cycle it is high, including while a frame is transmitting.
REQ-011 SHALL hold pending flags pend_g and pend_b.
- A pulse sets its own flag.
- A flag clears when the FSM loads the matching frame.
REQ-012 SHALL send a 14-byte frame for each pending flag, in this byte order:
- 'n'
- '0' for good or '1' for bad
- '.', 'v', 'a', 'l', '='
- four ASCII digits of the counter, most significant first, sampled when the frame is loaded
- 0xFF, 0xFF, 0xFF
REQ-013 SHALL use FSM states IDLE, LOAD, SEND, NEXT.
- IDLE -> LOAD when any flag is set.
- LOAD: latches the frame type and the digit snapshot, clears the matching flag, then -> SEND.
- SEND: starts one byte, then waits for the byte to complete, then -> NEXT.
- NEXT: after byte 13 -> IDLE; otherwise advances the byte index and -> SEND.
REQ-014 SHALL give a good frame priority when both flags are set, including when good_i and bad_i are high in the same cycle.
REQ-015 SHALL coalesce repeated pulses of one type during a transmission into one pending frame, which carries the latest count.
REQ-016 SHALL use a bit period of CLK_FREQ/UART_BPS cycles, truncated (2812 at the default parameters).
REQ-017 SHALL frame each byte as one start bit (0), eight data bits LSB first, and one stop bit (1).
REQ-018 SHALL drive the start bit on uart_tx_o exactly 3 cycles after the cycle in which a pulse is sampled with the FSM in IDLE.
REQ-019 SHALL send consecutive bytes of a frame with no idle gap beyond the stop bit plus at most 2 cycles.
REQ-020 SHALL assert busy_o from the cycle after a pulse until the cycle after the last stop bit of the last pending frame.

Reset
REQ-021 SHALL, while rst_i is high, immediately force:
- uart_tx_o = 1, busy_o = 0
- counters = 0000, flags = 0, FSM = IDLE
REQ-022 SHALL abort any frame in progress when reset asserts mid-frame, with the line returning high immediately and no further bytes sent after release.
REQ-023 SHALL ignore pulses in the cycle in which rst_i deasserts.

Configuration
REQ-024 SHALL, when macro REPORT_RATE_EN is defined, also maintain a total counter (good+bad, 4-digit BCD, wrapping).
- After each good or bad frame, send an extra 'n2.val=' frame with the total, in the same 14-byte format.
REQ-025 SHALL, when REPORT_RATE_EN is undefined, contain no total counter and send no n2 frame.

Structure
REQ-026 SHALL place shared constants in package report_pkg:
- frame length 14
- terminator byte 0xFF
- ASCII prefix bytes
- FSM state encodings
REQ-027 SHALL implement byte serialisation in a single sub-module uart_byte_tx, with ports:
- clk_i, rst_i
- start_i, data_i[7:0]
- tx_o, done_o (done_o a one-cycle pulse at the end of the stop bit)
REQ-028 SHALL implement BCD increment as per-digit carry logic, with no binary-to-BCD divider.

Verification (use CLK_FREQ=1000, UART_BPS=100, giving 10 cycles per bit)
REQ-029 SHALL cover: one good_i pulse from reset -> start bit 3 cycles later; the decoded bytes are "n0.val=0001" followed by FF FF FF; busy_o then drops.
REQ-030 SHALL cover: good_i and bad_i high in the same cycle -> the "n0.val=0001" frame, then the "n1.val=0001" frame; both counters read 1.
REQ-031 SHALL cover: three bad_i pulses during one good frame -> exactly one bad frame follows, reading "n1.val=0003".
REQ-032 SHALL cover: 10000 good_i pulses with transmission ignored -> the next frame reads "n0.val=0000" and then "n0.val=0001" after one more pulse.
REQ-033 SHALL cover: rst_i asserted in the middle of byte 5 -> uart_tx_o high within the same cycle; after release, no bytes until a new pulse, and the first frame then reads "0001".
REQ-034 SHALL cover, with REPORT_RATE_EN defined: one good pulse then one bad pulse -> frames "n0=0001", "n2=0001", "n1=0001", "n2=0002".
